core_lsu: RTL and testbench
===========================

// Module: core_lsu
// PURPOSE
//  Load/store unit sitting between the core's MEMORY stage and the data memory port.
//  Accepts one byte/half/word access per request and drives word-aligned memory with byte enables.
//  Waits on a memory acknowledge handshake, then returns sign- or zero-extended load data.
//  Replaces the core's raw single-cycle MEM_ADDR/MEM_DATA/MEM_WE path.
// PARAMETERS
//  ACK_TIMEOUT  255  max ACCESS cycles waiting for MEM_ACK before error; 0 = wait forever
// PORTS
//  CLK           in   1   clock, all state on rising edge
//  RST_N         in   1   reset, asynchronous, active-low
//  REQ_VALID     in   1   core request strobe
//  REQ_READY     out  1   unit idle, request accepted when VALID&READY
//  REQ_WE        in   1   1=store, 0=load
//  REQ_SIZE      in   2   0=byte 1=half 2=word 3=reserved
//  REQ_UNSIGNED  in   1   load zero-extend (LBU/LHU); ignored for stores/word
//  REQ_ADDR      in   32  byte address
//  REQ_WDATA     in   32  store data, LSBs significant
//  RSP_VALID     out  1   one-cycle completion pulse
//  RSP_RDATA     out  32  extended load data; 0 for stores and errors
//  RSP_ERR       out  1   access failed (reserved size, misalign, timeout); valid with RSP_VALID
//  MEM_ADDR      out  32  {REQ_ADDR[31:2],2'b00}
//  MEM_DATA      out  32  lane-replicated store data
//  MEM_BE        out  4   byte enables
//  MEM_WE        out  1   write strobe, held until MEM_ACK
//  MEM_RE        out  1   read strobe, held until MEM_ACK
//  MEM_IN        in   32  read data, sampled when MEM_ACK=1
//  MEM_ACK       in   1   memory completion
// BEHAVIOUR
//  Reset: state IDLE; REQ_READY=1; all other outputs 0; timeout counter 0. Async assert drops MEM_WE/RE immediately.
//  FSM IDLE -> ACCESS -> RESP -> IDLE.
//   IDLE: READY=1. On VALID: latch addr/size/we/unsigned/wdata.
//     Error request (size 3, or misaligned under the macro) -> RESP with ERR=1; no memory strobe.
//     Otherwise -> ACCESS.
//   ACCESS: READY=0; MEM_* stable from registered copies; MEM_WE=we, MEM_RE=~we.
//     MEM_ACK=1 -> latch MEM_IN, -> RESP.
//     Else counter++; counter==ACK_TIMEOUT (nonzero) -> RESP with ERR=1, strobes drop.
//   RESP: RSP_VALID=1 exactly one cycle; READY=0; -> IDLE.
//  Latency: accept at edge N, ACK in first ACCESS cycle -> RSP_VALID during cycle N+2. Throughput 1 req / 3 cycles min.
//  Byte lanes:
//   BE: byte=4'b0001<<a[1:0]; half=4'b0011<<{a[1],1'b0}; word=4'b1111.
//   MEM_DATA: byte={4{d[7:0]}}; half={2{d[15:0]}}; word=d.
//  Load extract:
//   byte=MEM_IN[8*a[1:0]+:8]; half=MEM_IN[16*a[1]+:16].
//   Sign-extend from bit 7/15 unless unsigned.
//  ACK arriving in IDLE/RESP: ignored. MEM_ACK and timeout in same cycle: ACK wins, ERR=0.
//  Counter clears on entry to ACCESS.
// CONFIGURATION
//  LSU_MISALIGN_TRAP_EN defined: half with a[0]=1 or word with a[1:0]!=0 -> ERR, no memory access.
//  Undefined: offending low address bits forced to 0 (aligned down), access proceeds, ERR=0.
// STRUCTURE
//  core_pkg: localparams LSU_SIZE_B/H/W/RSV (2'd0..3), FSM state encodings (one-hot, 3 bits).
//  Sub-module core_lsu_align: combinational BE/MEM_DATA generation, load extract/extend, misalign detect.
//  core_lsu holds FSM, request registers, timeout counter, response registers.
// TESTING
//  1. SW addr 0x100 data 0xDEADBEEF, ACK 1st cycle -> MEM_BE=4'hF, MEM_DATA=0xDEADBEEF, MEM_WE 1 cycle, RSP_VALID at N+2, RDATA=0.
//  2. LB addr 0x103, MEM_IN=0x80112233 -> BE=4'h8, RDATA=0xFFFFFF80; LBU same -> 0x00000080.
//  3. SH addr 0x102 data 0x0000ABCD -> MEM_ADDR=0x100, BE=4'hC, MEM_DATA=0xABCDABCD; LH addr 0x102, MEM_IN=0x8001xxxx -> RDATA=0xFFFF8001.
//  4. LW addr 0x101:
//     with macro -> RSP_ERR=1 at N+1 RESP, MEM_RE never high;
//     without -> MEM_ADDR=0x100, BE=4'hF, ERR=0.
//  5. ACK_TIMEOUT=4, MEM_ACK held 0 -> MEM_RE high 4 cycles then RSP_VALID with ERR=1; late ACK in IDLE ignored.
//  6. RST_N low mid-ACCESS -> MEM_RE=0 asynchronously, REQ_READY=1 after release; REQ_SIZE=3 -> ERR=1, no strobe.

Source files
------------

// File: rtl/core_pkg.sv
// ----------------------------------------------------------------------------
// core_pkg
//  Shared definitions for the load/store unit.
//  - LSU_SIZE_*  : access size codes carried on the request size field
//  - lsu_state_e : one-hot LSU FSM state encoding
// ----------------------------------------------------------------------------
package core_pkg;

    localparam logic [1:0] LSU_SIZE_B   = 2'd0;
    localparam logic [1:0] LSU_SIZE_H   = 2'd1;
    localparam logic [1:0] LSU_SIZE_W   = 2'd2;
    localparam logic [1:0] LSU_SIZE_RSV = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'b001,
        ST_ACCESS = 3'b010,
        ST_RESP   = 3'b100
    } lsu_state_e;

endpackage

// File: rtl/core_lsu_align.sv
// ----------------------------------------------------------------------------
// core_lsu_align
//  Combinational byte-lane logic for the LSU.
//  Store side (fed from the live request): byte enables, lane-replicated
//  store data, and a request-error flag (reserved size, plus misalignment
//  when LSU_MISALIGN_TRAP_EN is defined).
//  Load side (fed from the latched request): lane extract and sign/zero extend.
//  Ports:
//   i_st_size, i_st_addr_lo, i_st_wdata -> o_st_be, o_st_data, o_st_err
//   i_ld_size, i_ld_addr_lo, i_ld_unsigned, i_mem_in -> o_ld_data
//  Config macro: LSU_MISALIGN_TRAP_EN
// ----------------------------------------------------------------------------
module core_lsu_align
    import core_pkg::*;
(
    input  logic [1:0]  i_st_size,
    input  logic [1:0]  i_st_addr_lo,
    input  logic [31:0] i_st_wdata,
    output logic [3:0]  o_st_be,
    output logic [31:0] o_st_data,
    output logic        o_st_err,
    input  logic [1:0]  i_ld_size,
    input  logic [1:0]  i_ld_addr_lo,
    input  logic        i_ld_unsigned,
    input  logic [31:0] i_mem_in,
    output logic [31:0] o_ld_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Low address bits that do not fit the size are simply ignored here, which
    // gives the aligned-down behaviour when misaligned accesses are not trapped.
    always_comb begin
        o_st_be   = 4'b0000;
        o_st_data = i_st_wdata;
        case (i_st_size)
            LSU_SIZE_B: begin
                o_st_be   = 4'b0001 << i_st_addr_lo;
                o_st_data = {4{i_st_wdata[7:0]}};
            end
            LSU_SIZE_H: begin
                o_st_be   = 4'b0011 << {i_st_addr_lo[1], 1'b0};
                o_st_data = {2{i_st_wdata[15:0]}};
            end
            LSU_SIZE_W: o_st_be = 4'b1111;
            default:    o_st_be = 4'b0000;
        endcase
    end

`ifdef LSU_MISALIGN_TRAP_EN
    logic w_misalign;
    assign w_misalign = ((i_st_size == LSU_SIZE_H) && i_st_addr_lo[0]) ||
                        ((i_st_size == LSU_SIZE_W) && (i_st_addr_lo != 2'b00));
    assign o_st_err   = (i_st_size == LSU_SIZE_RSV) || w_misalign;
`else
    assign o_st_err   = (i_st_size == LSU_SIZE_RSV);
`endif

    always_comb begin
        case (i_ld_addr_lo)
            2'd0:    w_byte = i_mem_in[7:0];
            2'd1:    w_byte = i_mem_in[15:8];
            2'd2:    w_byte = i_mem_in[23:16];
            default: w_byte = i_mem_in[31:24];
        endcase
    end

    assign w_half = i_ld_addr_lo[1] ? i_mem_in[31:16] : i_mem_in[15:0];

    always_comb begin
        case (i_ld_size)
            LSU_SIZE_B: o_ld_data = {{24{w_byte[7]  & ~i_ld_unsigned}}, w_byte};
            LSU_SIZE_H: o_ld_data = {{16{w_half[15] & ~i_ld_unsigned}}, w_half};
            default:    o_ld_data = i_mem_in;
        endcase
    end

endmodule

// File: rtl/core_lsu.sv
// ----------------------------------------------------------------------------
// core_lsu
//  Load/store unit between the core MEMORY stage and a word-aligned data
//  memory with byte enables and an acknowledge handshake.
//  FSM: IDLE -> ACCESS -> RESP -> IDLE (error requests skip ACCESS).
//  Parameter: ACK_TIMEOUT - ACCESS cycles without ACK before an error
//             response; 0 waits forever.
//  Ports:
//   i_clk, i_rst_n (async, active-low)
//   request : i_req_valid, o_req_ready, i_req_we, i_req_size, i_req_unsigned,
//             i_req_addr, i_req_wdata
//   response: o_rsp_valid (1-cycle pulse), o_rsp_rdata, o_rsp_err
//   memory  : o_mem_addr, o_mem_data, o_mem_be, o_mem_we, o_mem_re,
//             i_mem_in, i_mem_ack
//  Config macro: LSU_MISALIGN_TRAP_EN (trap misaligned half/word accesses)
// ----------------------------------------------------------------------------
module core_lsu
    import core_pkg::*;
#(
    parameter int ACK_TIMEOUT = 255
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_we,
    input  logic [1:0]  i_req_size,
    input  logic        i_req_unsigned,
    input  logic [31:0] i_req_addr,
    input  logic [31:0] i_req_wdata,
    output logic        o_rsp_valid,
    output logic [31:0] o_rsp_rdata,
    output logic        o_rsp_err,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_data,
    output logic [3:0]  o_mem_be,
    output logic        o_mem_we,
    output logic        o_mem_re,
    input  logic [31:0] i_mem_in,
    input  logic        i_mem_ack
);

    localparam int             CW     = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT + 1) : 1;
    localparam logic [CW-1:0]  TO_VAL = CW'(ACK_TIMEOUT);

    lsu_state_e    r_state;
    logic          r_ready;
    logic          r_we;
    logic [1:0]    r_size;
    logic [1:0]    r_addr_lo;
    logic          r_unsigned;
    logic [31:0]   r_mem_addr;
    logic [31:0]   r_mem_data;
    logic [3:0]    r_mem_be;
    logic          r_mem_we;
    logic          r_mem_re;
    logic [CW-1:0] r_cnt;
    logic          r_rsp_valid;
    logic [31:0]   r_rsp_rdata;
    logic          r_rsp_err;

    logic [3:0]    w_st_be;
    logic [31:0]   w_st_data;
    logic          w_st_err;
    logic [31:0]   w_ld_data;
    logic [CW-1:0] w_cnt_nxt;

    core_lsu_align u_align (
        .i_st_size     (i_req_size),
        .i_st_addr_lo  (i_req_addr[1:0]),
        .i_st_wdata    (i_req_wdata),
        .o_st_be       (w_st_be),
        .o_st_data     (w_st_data),
        .o_st_err      (w_st_err),
        .i_ld_size     (r_size),
        .i_ld_addr_lo  (r_addr_lo),
        .i_ld_unsigned (r_unsigned),
        .i_mem_in      (i_mem_in),
        .o_ld_data     (w_ld_data)
    );

    assign w_cnt_nxt = r_cnt + CW'(1);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= ST_IDLE;
            r_ready     <= 1'b1;
            r_we        <= 1'b0;
            r_size      <= 2'd0;
            r_addr_lo   <= 2'd0;
            r_unsigned  <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_data  <= '0;
            r_mem_be    <= '0;
            r_mem_we    <= 1'b0;
            r_mem_re    <= 1'b0;
            r_cnt       <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_req_valid) begin
                        r_ready    <= 1'b0;
                        r_we       <= i_req_we;
                        r_size     <= i_req_size;
                        r_addr_lo  <= i_req_addr[1:0];
                        r_unsigned <= i_req_unsigned;
                        r_mem_addr <= {i_req_addr[31:2], 2'b00};
                        r_mem_data <= w_st_data;
                        r_cnt      <= '0;
                        if (w_st_err) begin
                            // Rejected before touching memory: strobes stay low.
                            r_state     <= ST_RESP;
                            r_rsp_valid <= 1'b1;
                            r_rsp_err   <= 1'b1;
                            r_rsp_rdata <= '0;
                        end else begin
                            r_state  <= ST_ACCESS;
                            r_mem_be <= w_st_be;
                            r_mem_we <= i_req_we;
                            r_mem_re <= ~i_req_we;
                        end
                    end
                end
                ST_ACCESS: begin
                    // ACK is checked first so it wins over a coincident timeout.
                    if (i_mem_ack) begin
                        r_state     <= ST_RESP;
                        r_mem_be    <= '0;
                        r_mem_we    <= 1'b0;
                        r_mem_re    <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= 1'b0;
                        r_rsp_rdata <= r_we ? 32'd0 : w_ld_data;
                    end else begin
                        r_cnt <= w_cnt_nxt;
                        if ((ACK_TIMEOUT != 0) && (w_cnt_nxt == TO_VAL)) begin
                            r_state     <= ST_RESP;
                            r_mem_be    <= '0;
                            r_mem_we    <= 1'b0;
                            r_mem_re    <= 1'b0;
                            r_rsp_valid <= 1'b1;
                            r_rsp_err   <= 1'b1;
                            r_rsp_rdata <= '0;
                        end
                    end
                end
                ST_RESP: begin
                    r_state     <= ST_IDLE;
                    r_ready     <= 1'b1;
                    r_rsp_valid <= 1'b0;
                    r_rsp_err   <= 1'b0;
                    r_rsp_rdata <= '0;
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_ready     <= 1'b1;
                    r_mem_be    <= '0;
                    r_mem_we    <= 1'b0;
                    r_mem_re    <= 1'b0;
                    r_rsp_valid <= 1'b0;
                    r_rsp_err   <= 1'b0;
                    r_rsp_rdata <= '0;
                end
            endcase
        end
    end

    assign o_req_ready = r_ready;
    assign o_rsp_valid = r_rsp_valid;
    assign o_rsp_rdata = r_rsp_rdata;
    assign o_rsp_err   = r_rsp_err;
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_data  = r_mem_data;
    assign o_mem_be    = r_mem_be;
    assign o_mem_we    = r_mem_we;
    assign o_mem_re    = r_mem_re;

endmodule

// File: tb/tb_core_lsu.sv
module tb_core_lsu;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_we, req_uns;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        req_ready, rsp_valid, rsp_err;
    logic [31:0] rsp_rdata, mem_addr, mem_data, mem_in;
    logic [3:0]  mem_be;
    logic        mem_we, mem_re, mem_ack;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    core_lsu #(.ACK_TIMEOUT(TO)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_we(req_we),
        .i_req_size(req_size), .i_req_unsigned(req_uns), .i_req_addr(req_addr),
        .i_req_wdata(req_wdata),
        .o_rsp_valid(rsp_valid), .o_rsp_rdata(rsp_rdata), .o_rsp_err(rsp_err),
        .o_mem_addr(mem_addr), .o_mem_data(mem_data), .o_mem_be(mem_be),
        .o_mem_we(mem_we), .o_mem_re(mem_re), .i_mem_in(mem_in), .i_mem_ack(mem_ack)
    );

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] memin;
        int          dly;    // ACK on access cycle dly+1; >=TO means never
        int          lat;    // negedges after accept edge until RSP_VALID
        int          nwe;
        int          nre;
        logic [3:0]  be;
        logic [31:0] mdata;
        logic [31:0] rdata;
        logic        err;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Reference model: expected outcome from the access rules, by arithmetic.
    function automatic vec_t model(input vec_t v);
        vec_t        r;
        int          off;
        logic [31:0] x;
        logic [31:0] ext;
        bit          rej;
        r   = v;
        off = int'(v.addr % 4);
        rej = (v.size == 2'd3);
`ifdef LSU_MISALIGN_TRAP_EN
        if ((v.size == 2'd1 && off % 2 != 0) || (v.size == 2'd2 && off != 0)) rej = 1'b1;
`endif
        ext     = v.memin;
        r.be    = 4'hF;
        r.mdata = v.wdata;
        if (v.size == 2'd0) begin
            r.be    = 4'(1 << off);
            r.mdata = (v.wdata & 32'hFF) * 32'h01010101;
            x       = (v.memin >> (8 * off)) & 32'hFF;
            ext     = (!v.uns && x >= 32'h80) ? x + 32'hFFFFFF00 : x;
        end else if (v.size == 2'd1) begin
            off     = off - (off % 2);
            r.be    = 4'(3 << off);
            r.mdata = (v.wdata & 32'hFFFF) * 32'h00010001;
            x       = (v.memin >> (8 * off)) & 32'hFFFF;
            ext     = (!v.uns && x >= 32'h8000) ? x + 32'hFFFF0000 : x;
        end
        if (rej) begin
            r.lat = 1; r.nwe = 0; r.nre = 0; r.err = 1'b1; r.rdata = 0;
        end else begin
            r.nwe   = 0;
            r.nre   = 0;
            r.lat   = (v.dly >= TO) ? TO + 1 : v.dly + 2;
            r.err   = (v.dly >= TO);
            r.rdata = (v.we || v.dly >= TO) ? 32'd0 : ext;
            if (v.we) r.nwe = (v.dly >= TO) ? TO : v.dly + 1;
            else      r.nre = (v.dly >= TO) ? TO : v.dly + 1;
        end
        return r;
    endfunction

    task automatic run_txn(input vec_t v, input string tag);
        int          lat, nwe, nre;
        logic [31:0] a_addr, a_data, rd;
        logic [3:0]  a_be;
        logic        er;
        lat = 0; nwe = 0; nre = 0; a_addr = 0; a_data = 0; a_be = 0; rd = 0; er = 0;
        @(negedge clk);
        chk({tag, " ready"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_we = v.we; req_size = v.size; req_uns = v.uns;
        req_addr = v.addr; req_wdata = v.wdata;
        @(negedge clk);
        // Scramble request inputs: the unit must use its latched copy.
        req_valid = 1'b0; req_we = ~v.we; req_size = 2'($urandom);
        req_uns = ~v.uns; req_addr = $urandom; req_wdata = $urandom;
        for (int c = 1; c <= 20; c++) begin
            mem_ack = 1'b0;
            mem_in  = $urandom;
            if (rsp_valid) begin
                lat = c; rd = rsp_rdata; er = rsp_err;
                break;
            end
            if (mem_we || mem_re) begin
                if (mem_we) nwe++;
                if (mem_re) nre++;
                a_addr = mem_addr; a_be = mem_be; a_data = mem_data;
                if (nwe + nre == v.dly + 1) begin
                    mem_ack = 1'b1;
                    mem_in  = v.memin;
                end
            end
            @(negedge clk);
        end
        chk({tag, " latency"}, 32'(lat), 32'(v.lat));
        chk({tag, " we_cycles"}, 32'(nwe), 32'(v.nwe));
        chk({tag, " re_cycles"}, 32'(nre), 32'(v.nre));
        chk({tag, " rsp_err"}, 32'(er), 32'(v.err));
        chk({tag, " rsp_rdata"}, rd, v.rdata);
        if (v.nwe + v.nre > 0) begin
            chk({tag, " mem_addr"}, a_addr, v.addr & 32'hFFFF_FFFC);
            chk({tag, " mem_be"}, 32'(a_be), 32'(v.be));
        end
        if (v.nwe > 0) chk({tag, " mem_data"}, a_data, v.mdata);
        @(negedge clk);
        chk({tag, " rsp_pulse"}, 32'(rsp_valid), 32'd0);
        chk({tag, " ready_after"}, 32'(req_ready), 32'd1);
    endtask

    vec_t tbl[10];
    vec_t rv;

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_uns = 1'b0;
        req_addr = 0; req_wdata = 0; mem_in = 0; mem_ack = 1'b0;

        //        we    size  uns   addr          wdata         memin         dly lat nwe nre be     mdata         rdata         err
        tbl[0] = '{1'b1, 2'd2, 1'b0, 32'h00000100, 32'hDEADBEEF, 32'h00000000, 0,  2,  1,  0,  4'hF, 32'hDEADBEEF, 32'h00000000, 1'b0};
        tbl[1] = '{1'b0, 2'd0, 1'b0, 32'h00000103, 32'h0,        32'h80112233, 0,  2,  0,  1,  4'h8, 32'h0,        32'hFFFFFF80, 1'b0};
        tbl[2] = '{1'b0, 2'd0, 1'b1, 32'h00000103, 32'h0,        32'h80112233, 1,  3,  0,  2,  4'h8, 32'h0,        32'h00000080, 1'b0};
        tbl[3] = '{1'b1, 2'd1, 1'b0, 32'h00000102, 32'h0000ABCD, 32'h0,        0,  2,  1,  0,  4'hC, 32'hABCDABCD, 32'h00000000, 1'b0};
        tbl[4] = '{1'b0, 2'd1, 1'b0, 32'h00000102, 32'h0,        32'h80015555, 0,  2,  0,  1,  4'hC, 32'h0,        32'hFFFF8001, 1'b0};
`ifdef LSU_MISALIGN_TRAP_EN
        tbl[5] = '{1'b0, 2'd2, 1'b0, 32'h00000101, 32'h0,        32'h12345678, 0,  1,  0,  0,  4'h0, 32'h0,        32'h00000000, 1'b1};
`else
        tbl[5] = '{1'b0, 2'd2, 1'b0, 32'h00000101, 32'h0,        32'h12345678, 0,  2,  0,  1,  4'hF, 32'h0,        32'h12345678, 1'b0};
`endif
        tbl[6] = '{1'b0, 2'd2, 1'b0, 32'h00000200, 32'h0,        32'h55AA55AA, 99, 5,  0,  4,  4'hF, 32'h0,        32'h00000000, 1'b1};
        tbl[7] = '{1'b0, 2'd2, 1'b0, 32'h00000204, 32'h0,        32'hCAFEF00D, 3,  5,  0,  4,  4'hF, 32'h0,        32'hCAFEF00D, 1'b0};
        tbl[8] = '{1'b1, 2'd3, 1'b0, 32'h00000300, 32'h11223344, 32'h0,        0,  1,  0,  0,  4'h0, 32'h0,        32'h00000000, 1'b1};
        tbl[9] = '{1'b1, 2'd0, 1'b0, 32'h00000301, 32'h000000A5, 32'h0,        2,  4,  3,  0,  4'h2, 32'hA5A5A5A5, 32'h00000000, 1'b0};

        repeat (3) @(negedge clk);
        chk("reset ready", 32'(req_ready), 32'd1);
        chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset strobes", 32'({mem_we, mem_re}), 32'd0);
        chk("reset be", 32'(mem_be), 32'd0);
        chk("reset addr", mem_addr, 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) run_txn(tbl[i], $sformatf("vec%0d", i));

        // ACK arriving while idle must not produce a response or strobe.
        @(negedge clk);
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        chk("idle_ack rsp_valid", 32'(rsp_valid), 32'd0);
        chk("idle_ack ready", 32'(req_ready), 32'd1);
        chk("idle_ack strobes", 32'({mem_we, mem_re}), 32'd0);
        @(negedge clk);
        chk("idle_ack rsp_valid2", 32'(rsp_valid), 32'd0);

        // Asynchronous reset in the middle of an access.
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_addr = 32'h400;
        @(negedge clk);
        req_valid = 1'b0;
        chk("rst_mid re_before", 32'(mem_re), 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_mid re_async", 32'(mem_re), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_mid ready", 32'(req_ready), 32'd1);
        chk("rst_mid rsp_valid", 32'(rsp_valid), 32'd0);

        for (int i = 0; i < 60; i++) begin
            rv.we    = 1'($urandom);
            rv.size  = 2'($urandom);
            rv.uns   = 1'($urandom);
            rv.addr  = $urandom;
            rv.wdata = $urandom;
            rv.memin = $urandom;
            rv.dly   = (($urandom % 8) == 0) ? 50 : int'($urandom_range(0, 3));
            run_txn(model(rv), $sformatf("rnd%0d", i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
